shift_sequencer: RTL and testbench

- Multi-cycle controller that performs a 32-bit variable-amount shift by sequencing one power-of-two shift stage per clock: 16, then 8, 4, 2, 1.
- Each stage is applied or bypassed according to the corresponding bit of the shift amount.
- Sits beside the ALU as the SLL/SRL/SRA engine, for designs that do not afford a full single-cycle barrel shifter.
- Uses start/busy/done handshaking toward the ALU control unit.

---
 rtl/shift_pkg.sv | 27 ++
 rtl/shift_stage_select.sv | 53 +++++
 rtl/shift_sequencer.sv | 128 ++++++++++++
 tb/tb_shift_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the multi-cycle shift sequencer:
//   - state_e    : controller state encoding (IDLE / SHIFT / DONE)
//   - DIR_*      : shift direction encoding of the 'direction' input
//   - MODE_*     : right-shift fill encoding of the 'aritmetic_logic' input
// -----------------------------------------------------------------------------
package shift_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic DIR_LEFT   = 1'b0;
    localparam logic DIR_RIGHT  = 1'b1;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    // True when a stage must replicate the operand sign into vacated bits.
    function automatic logic sign_fill(input logic dir, input logic mode);
        return (dir == DIR_RIGHT) && (mode == MODE_ARITH);
    endfunction

endpackage

// File: rtl/shift_stage_select.sv
// -----------------------------------------------------------------------------
// shift_stage_select
// Combinational single-stage shifter. Shifts acc_i by 2^idx_i when enable_i
// is set, otherwise passes acc_i through.
//   acc_i       in  WIDTH    current accumulator value
//   idx_i       in  IDX_W    stage index, shift distance is 2^idx_i
//   direction_i in  1        0 = left, 1 = right
//   mode_i      in  1        right fill: 0 = sign, 1 = zero
//   enable_i    in  1        apply this stage (shift-amount bit for idx_i)
//   stage_o     out WIDTH    stage result
// -----------------------------------------------------------------------------
module shift_stage_select
    import shift_pkg::*;
#(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH),
    localparam int IDX_W   = $clog2(SHAMT_W)
) (
    input  logic [WIDTH-1:0] acc_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic             direction_i,
    input  logic             mode_i,
    input  logic             enable_i,
    output logic [WIDTH-1:0] stage_o
);

    logic             fill_s;
    logic [WIDTH-1:0] right_s [SHAMT_W];
    logic [WIDTH-1:0] left_s  [SHAMT_W];
    logic [WIDTH-1:0] sel_s;

    // Every arithmetic stage keeps the MSB, so the current MSB is always the
    // original operand sign.
    assign fill_s = sign_fill(direction_i, mode_i) ? acc_i[WIDTH-1] : 1'b0;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        assign right_s[k] = {{SH{fill_s}}, acc_i[WIDTH-1:SH]};
        assign left_s[k]  = {acc_i[WIDTH-1-SH:0], {SH{1'b0}}};
    end

    // One-hot AND-OR mux of the per-distance candidates, selected by idx_i.
    always_comb begin
        sel_s = {WIDTH{1'b0}};
        for (int k = 0; k < SHAMT_W; k++) begin
            sel_s = sel_s | ({WIDTH{idx_i == IDX_W'(k)}} &
                             ((direction_i == DIR_LEFT) ? left_s[k] : right_s[k]));
        end
    end

    assign stage_o = enable_i ? sel_s : acc_i;

endmodule

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
// Multi-cycle variable shifter: applies one power-of-two stage per clock
// (WIDTH/2 down to 1), each gated by the matching shift-amount bit. Latency is
// fixed at SHAMT_W shift cycles regardless of the amount.
//   clock           in  1        rising-edge clock
//   reset           in  1        synchronous active-high reset
//   start           in  1        request; accepted in IDLE or DONE
//   abort           in  1        cancel while shifting (no done pulse)
//   regi            in  WIDTH    operand
//   shamt           in  SHAMT_W  shift amount
//   direction       in  1        0 = left, 1 = right
//   aritmetic_logic in  1        right fill: 0 = sign, 1 = zero
//   busy            out 1        high in SHIFT
//   done            out 1        one-cycle pulse, result valid
//   result          out WIDTH    result, held until next completion
// -----------------------------------------------------------------------------
module shift_sequencer
    import shift_pkg::*;
#(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   regi,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               direction,
    input  logic               aritmetic_logic,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    localparam int IDX_W = $clog2(SHAMT_W);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(SHAMT_W - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   acc_d;
    logic [SHAMT_W-1:0] shamt_q;
    logic               dir_q;
    logic               mode_q;
    logic [IDX_W-1:0]   idx_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   result_q;
    logic               accept_s;

    // start is only honoured outside SHIFT; in DONE it overrides abort.
    assign accept_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    shift_stage_select #(
        .WIDTH (WIDTH)
    ) u_stage (
        .acc_i       (acc_q),
        .idx_i       (idx_q),
        .direction_i (dir_q),
        .mode_i      (mode_q),
        .enable_i    (shamt_q[idx_q]),
        .stage_o     (acc_d)
    );

    // Controller FSM, stage counter, datapath registers and registered flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= {WIDTH{1'b0}};
            shamt_q  <= {SHAMT_W{1'b0}};
            dir_q    <= 1'b0;
            mode_q   <= 1'b0;
            idx_q    <= {IDX_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            state_q <= S_SHIFT;
            acc_q   <= regi;
            shamt_q <= shamt;
            dir_q   <= direction;
            mode_q  <= aritmetic_logic;
            idx_q   <= IDX_TOP;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                S_SHIFT: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        if (idx_q == {IDX_W{1'b0}}) begin
                            result_q <= acc_d;
                            state_q  <= S_DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            idx_q <= idx_q - IDX_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
// Directed, table-driven bench for shift_sequencer (WIDTH=32), plus hand
// sequences for start-while-busy, back-to-back, abort and mid-shift reset.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

    typedef struct {
        logic [31:0] regi;
        logic [4:0]  shamt;
        logic        dir;
        logic        mode;
        logic [31:0] exp;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] regi;
    logic [4:0]  shamt;
    logic        direction;
    logic        aritmetic_logic;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_tests;
    int n_fail;
    vec_t vecs [10];

    shift_sequencer #(.WIDTH(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .regi            (regi),
        .shamt           (shamt),
        .direction       (direction),
        .aritmetic_logic (aritmetic_logic),
        .busy            (busy),
        .done            (done),
        .result          (result)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic scramble();
        regi            = $urandom;
        shamt           = 5'($urandom);
        direction       = 1'($urandom);
        aritmetic_logic = 1'($urandom);
    endtask

    // Called at a negedge. Returns at the negedge where done is seen (or timeout).
    task automatic run_op(input vec_t v, input bit hold_start,
                          output int lat, output int bcnt, output int ovl,
                          output logic [31:0] res);
        regi            = v.regi;
        shamt           = v.shamt;
        direction       = v.dir;
        aritmetic_logic = v.mode;
        start           = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if (!hold_start) start = 1'b0;
        scramble();
        lat  = -1;
        bcnt = 0;
        ovl  = 0;
        res  = 32'h0;
        for (int k = 0; k < 20; k++) begin
            if (hold_start && k == 3) start = 1'b0;
            if (busy) bcnt++;
            if (busy && done) ovl++;
            if (done) begin
                lat = k;
                res = result;
                break;
            end
            @(negedge clock);
        end
        start = 1'b0;
    endtask

    task automatic check_op(input string tag, input vec_t v, input bit hold_start);
        int lat, bcnt, ovl;
        logic [31:0] res;
        run_op(v, hold_start, lat, bcnt, ovl, res);
        check({tag, "_latency"}, 32'(lat), 32'd5);
        check({tag, "_busy_cycles"}, 32'(bcnt), 32'd5);
        check({tag, "_busy_done_overlap"}, 32'(ovl), 32'd0);
        check({tag, "_result"}, res, v.exp);
    endtask

    initial begin
        int   gap;
        bit   seen_done;
        vec_t v;

        n_tests = 0;
        n_fail  = 0;

        //            regi          shamt  dir   mode  expected
        vecs[0] = '{32'h8000_00F0, 5'd4,  1'b1, 1'b1, 32'h0800_000F};
        vecs[1] = '{32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'hFFFF_FFFF};
        vecs[2] = '{32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'h0000_0001};
        vecs[3] = '{32'h0000_0001, 5'd17, 1'b0, 1'b0, 32'h0002_0000};
        vecs[4] = '{32'h0000_0001, 5'd0,  1'b0, 1'b1, 32'h0000_0001};
        vecs[5] = '{32'hF0F0_0000, 5'd8,  1'b1, 1'b0, 32'hFFF0_F000};
        vecs[6] = '{32'h1234_5678, 5'd4,  1'b0, 1'b1, 32'h2345_6780};
        vecs[7] = '{32'h7000_0000, 5'd28, 1'b1, 1'b0, 32'h0000_0007};
        vecs[8] = '{32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 32'h8000_0000};
        vecs[9] = '{32'hFFFF_0000, 5'd16, 1'b1, 1'b1, 32'h0000_FFFF};

        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        regi  = 32'h0;
        shamt = 5'd0;
        direction       = 1'b0;
        aritmetic_logic = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Table-driven vectors, each followed by a one-cycle-pulse check.
        for (int i = 0; i < 10; i++) begin
            check_op($sformatf("v%0d", i), vecs[i], 1'b0);
            @(negedge clock);
            check($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
        end

        // start held high while busy must be ignored.
        v = '{32'h1234_5678, 5'd12, 1'b1, 1'b0, 32'h0001_2345};
        check_op("hold_start", v, 1'b1);
        @(negedge clock);
        check("hold_start_idle_busy", {31'd0, busy}, 32'd0);
        check("hold_start_idle_done", {31'd0, done}, 32'd0);

        // Back-to-back: start (with abort) in DONE; next done 6 cycles later.
        check_op("b2b_first", vecs[0], 1'b0);
        regi            = 32'hFFFF_0000;
        shamt           = 5'd16;
        direction       = 1'b1;
        aritmetic_logic = 1'b1;
        start           = 1'b1;
        abort           = 1'b1;
        @(negedge clock);
        gap   = 1;
        start = 1'b0;
        abort = 1'b0;
        scramble();
        while (!done && gap < 20) begin
            @(negedge clock);
            gap++;
        end
        check("b2b_gap", 32'(gap), 32'd6);
        check("b2b_result", result, 32'h0000_FFFF);

        // Abort mid-SHIFT after ignored starts: no done, result held.
        @(negedge clock);
        regi            = 32'h0000_0001;
        shamt           = 5'd1;
        direction       = 1'b0;
        aritmetic_logic = 1'b0;
        start           = 1'b1;
        @(posedge clock);
        @(negedge clock);
        scramble();
        @(negedge clock);
        @(negedge clock);
        start = 1'b0;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        seen_done = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (done || busy) seen_done = 1'b1;
        end
        check("abort_no_done", {31'd0, seen_done}, 32'd0);
        check("abort_result_held", result, 32'h0000_FFFF);
        check_op("after_abort", vecs[3], 1'b0);
        @(negedge clock);

        // Reset asserted during the third SHIFT cycle.
        regi            = 32'h1234_5678;
        shamt           = 5'd4;
        direction       = 1'b0;
        aritmetic_logic = 1'b1;
        start           = 1'b1;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_result", result, 32'h0);
        reset = 1'b0;
        seen_done = 1'b0;
        repeat (6) begin
            @(negedge clock);
            if (done || busy) seen_done = 1'b1;
        end
        check("midreset_stays_idle", {31'd0, seen_done}, 32'd0);
        check_op("after_reset", vecs[1], 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
